philo_fork_arbiter: RTL and testbench

- Central fork arbiter ("butler") that acts as the responder for a ring of N philosopher initiators.
- Each philosopher raises a hunger request. The arbiter grants EAT only when both of that philosopher's forks are free, and the philosopher returns the forks with a release pulse.
- Fork i is shared by philosopher i and philosopher (i+1) mod N. Philosopher i therefore needs forks i and (i-1) mod N, which makes neighbours mutually exclusive.
- A round-robin pointer gives bounded waiting. An eat-time watchdog reclaims forks from a philosopher that never releases.

---
 rtl/philo_fork_arbiter_if.sv | 15 +
 rtl/philo_fork_arbiter.sv | 118 +++++++++++
 tb/tb_philo_fork_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/philo_fork_arbiter_if.sv
// Philosopher <-> butler bundle: hunger requests and releases in, fork grants and status out.
interface philo_fork_arbiter_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned PW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  rel;
    logic [N-1:0]  grant;
    logic [N-1:0]  waiting;
    logic [N-1:0]  timeout;
    logic [PW-1:0] ptr;

    modport master (output req, rel, input grant, waiting, timeout, ptr);
    modport slave  (input req, rel, output grant, waiting, timeout, ptr);
endinterface

// File: rtl/philo_fork_arbiter.sv
// Dining-philosophers fork arbiter: round-robin, neighbour-exclusive EAT grants
// with a per-philosopher eat-time watchdog.
module philo_fork_arbiter #(
    parameter int unsigned N       = 8,
    parameter int unsigned EAT_MAX = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    philo_fork_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(EAT_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, EAT} phil_st_e;

    phil_st_e       st [N];
    logic [CW-1:0]  cnt [N];
    logic [N-1:0]   grant_q;
    logic [N-1:0]   waiting_q;
    logic [N-1:0]   timeout_q;
    logic [PW-1:0]  ptr_q;

    logic [N-1:0]   elig;
    logic [N-1:0]   sel;
    logic           found;
    logic [PW-1:0]  first;
    logic [PW-1:0]  idx;
    logic [PW-1:0]  lft;
    logic [PW-1:0]  rgt;
    int unsigned    tmp;
    logic [PW-1:0]  ptr_nxt;

    // grant_q mirrors state==EAT, so it doubles as the "fork in use" vector
    assign elig = bus.req & ~grant_q;

    // Round-robin scan from ptr; a candidate loses to any eating or already-selected neighbour
    always_comb begin
        sel   = '0;
        found = 1'b0;
        first = '0;
        tmp   = 0;
        idx   = '0;
        lft   = '0;
        rgt   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            tmp = int'(ptr_q) + k;
            if (tmp >= N) tmp = tmp - N;
            idx = PW'(tmp);
            lft = (idx == '0) ? PW'(N - 1) : idx - 1'b1;
            rgt = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            if (elig[idx] && !grant_q[lft] && !grant_q[rgt] && !sel[lft] && !sel[rgt]) begin
                sel[idx] = 1'b1;
                if (!found) begin
                    found = 1'b1;
                    first = idx;
                end
            end
        end
    end

    assign ptr_nxt = (first == PW'(N - 1)) ? '0 : first + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
            end
            grant_q   <= '0;
            waiting_q <= '0;
            timeout_q <= '0;
            ptr_q     <= '0;
        end else begin
            timeout_q <= '0;
            if (found) ptr_q <= ptr_nxt;
            for (int i = 0; i < int'(N); i++) begin
                case (st[i])
                    IDLE, WAIT: begin
                        if (sel[i]) begin
                            st[i]        <= EAT;
                            cnt[i]       <= '0;
                            grant_q[i]   <= 1'b1;
                            waiting_q[i] <= 1'b0;
                        end else if (bus.req[i]) begin
                            st[i]        <= WAIT;
                            waiting_q[i] <= 1'b1;
                        end else begin
                            st[i]        <= IDLE;
                            waiting_q[i] <= 1'b0;
                        end
                    end
                    EAT: begin
                        if (bus.rel[i]) begin
                            st[i]      <= IDLE;
                            grant_q[i] <= 1'b0;
                        end else if (cnt[i] == CW'(EAT_MAX - 1)) begin
                            st[i]        <= IDLE;
                            grant_q[i]   <= 1'b0;
                            timeout_q[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        st[i]        <= IDLE;
                        grant_q[i]   <= 1'b0;
                        waiting_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.waiting = waiting_q;
    assign bus.timeout = timeout_q;
    assign bus.ptr     = ptr_q;
endmodule

// File: tb/tb_philo_fork_arbiter.sv
// Scoreboard bench for philo_fork_arbiter: behavioural ring model plus directed plan checks.
module tb_philo_fork_arbiter;
    localparam int unsigned N       = 8;
    localparam int unsigned EAT_MAX = 16;
    localparam int unsigned PW      = $clog2(N);
    localparam int          BOUND   = 2 * N * EAT_MAX;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [N-1:0]  waiting;
        logic [N-1:0]  timeout;
        logic [PW-1:0] ptr;
    } exp_t;

    logic clock;
    logic reset;

    philo_fork_arbiter_if #(.N(N)) bus ();

    philo_fork_arbiter #(.N(N), .EAT_MAX(EAT_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    // Reference model: 0 IDLE, 1 WAIT, 2 EAT
    int m_st  [N];
    int m_cnt [N];
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
        m_ptr = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] rl, output exp_t e);
        logic [N-1:0] s;
        int first;
        s = '0;
        first = -1;
        for (int k = 0; k < int'(N); k++) begin
            int ix, l, r;
            ix = (m_ptr + k) % int'(N);
            l  = (ix + int'(N) - 1) % int'(N);
            r  = (ix + 1) % int'(N);
            if (rq[ix] && m_st[ix] != 2 && m_st[l] != 2 && m_st[r] != 2 && !s[l] && !s[r]) begin
                s[ix] = 1'b1;
                if (first < 0) first = ix;
            end
        end
        e.timeout = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (m_st[i] == 2) begin
                if (rl[i]) m_st[i] = 0;
                else if (m_cnt[i] == int'(EAT_MAX) - 1) begin
                    m_st[i] = 0;
                    e.timeout[i] = 1'b1;
                end else m_cnt[i]++;
            end else if (s[i]) begin
                m_st[i]  = 2;
                m_cnt[i] = 0;
            end else m_st[i] = rq[i] ? 1 : 0;
        end
        if (first >= 0) m_ptr = (first + 1) % int'(N);
        for (int i = 0; i < int'(N); i++) begin
            e.grant[i]   = (m_st[i] == 2);
            e.waiting[i] = (m_st[i] == 1);
        end
        e.ptr = PW'(m_ptr);
    endtask

    // One clock: drive, predict, advance, pop and compare, plus ring invariants
    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] rl);
        exp_t e;
        exp_t got;
        logic [N-1:0] pg;
        bus.req = rq;
        bus.rel = rl;
        model_step(rq, rl, e);
        sb_q.push_back(e);
        pg = bus.grant;
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        chk("grant",   32'(bus.grant),   32'(got.grant));
        chk("waiting", 32'(bus.waiting), 32'(got.waiting));
        chk("timeout", 32'(bus.timeout), 32'(got.timeout));
        chk("ptr",     32'(bus.ptr),     32'(got.ptr));
        chk("adjacent_grant", 32'(bus.grant & {bus.grant[0], bus.grant[N-1:1]}), 32'(0));
        chk("grant_and_wait", 32'(bus.grant & bus.waiting), 32'(0));
        chk("timeout_no_prev_grant", 32'(bus.timeout & ~pg), 32'(0));
        bus.rel = '0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d expected", 0);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       g3 [20];
        logic       t3 [20];
        int         hi;
        int         age [N];
        int         max_age;
        logic       wrapped;
        logic [PW-1:0] pp;
        logic [N-1:0]  rl;

        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        bus.req = '1;
        bus.rel = '1;
        model_reset();

        // Reset with arbitrary inputs, before and after a clock edge
        #3;
        chk("rst_grant",   32'(bus.grant),   32'(0));
        chk("rst_waiting", 32'(bus.waiting), 32'(0));
        chk("rst_timeout", 32'(bus.timeout), 32'(0));
        chk("rst_ptr",     32'(bus.ptr),     32'(0));
        @(posedge clock);
        #1;
        chk("rst_edge_grant", 32'(bus.grant), 32'(0));
        chk("rst_edge_ptr",   32'(bus.ptr),   32'(0));
        bus.req = '0;
        bus.rel = '0;
        reset   = 1'b0;

        // Single request, then release
        cycle(8'h01, 8'h00);
        chk("single_grant", 32'(bus.grant), 32'h01);
        chk("single_ptr",   32'(bus.ptr),   32'd1);
        cycle(8'h00, 8'h01);
        chk("single_rel_grant", 32'(bus.grant), 32'h00);
        do_reset();

        // Everyone hungry from ptr 0
        cycle(8'hFF, 8'h00);
        chk("all_grant",   32'(bus.grant),   32'h55);
        chk("all_waiting", 32'(bus.waiting), 32'hAA);
        chk("all_ptr",     32'(bus.ptr),     32'd1);
        do_reset();

        // Hand-over 0 -> 1 with one-cycle gap
        cycle(8'h03, 8'h00);
        chk("ho_grant0",   32'(bus.grant),   32'h01);
        chk("ho_waiting1", 32'(bus.waiting), 32'h02);
        cycle(8'h02, 8'h01);
        chk("ho_gap_grant", 32'(bus.grant),   32'h00);
        chk("ho_gap_wait",  32'(bus.waiting), 32'h02);
        cycle(8'h02, 8'h00);
        chk("ho_grant1", 32'(bus.grant), 32'h02);
        do_reset();

        // Asynchronous reset while philosopher 2 eats
        cycle(8'h04, 8'h00);
        chk("mid_grant2", 32'(bus.grant), 32'h04);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 32'h00);
        do_reset();

        // Watchdog on philosopher 3
        for (int c = 0; c < 20; c++) begin
            cycle(8'h08, 8'h00);
            g3[c] = bus.grant[3];
            t3[c] = bus.timeout[3];
        end
        hi = 0;
        for (int c = 0; c < 17; c++) hi += int'(g3[c]);
        chk("wd_eat_cycles", 32'(hi), 32'd16);
        chk("wd_drop_grant", 32'(g3[16]), 32'd0);
        chk("wd_timeout",    32'(t3[16]), 32'd1);
        chk("wd_timeout_end", 32'(t3[17]), 32'd0);
        chk("wd_regrant",    32'(g3[17]), 32'd1);
        do_reset();

        // Saturated ring, each eater releases on its third cycle
        for (int i = 0; i < int'(N); i++) age[i] = 0;
        max_age = 0;
        wrapped = 1'b0;
        for (int c = 0; c < 500; c++) begin
            rl = '0;
            for (int i = 0; i < int'(N); i++)
                if (m_st[i] == 2 && m_cnt[i] == 2) rl[i] = 1'b1;
            pp = bus.ptr;
            cycle(8'hFF, rl);
            if (pp == PW'(N - 1) && bus.ptr == '0) wrapped = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                age[i] = bus.grant[i] ? 0 : age[i] + 1;
                if (age[i] > max_age) max_age = age[i];
            end
        end
        chk("fair_bound", 32'(max_age <= BOUND), 32'd1);
        chk("ptr_wrap",   32'(wrapped), 32'd1);
        do_reset();

        // Random requests and releases
        for (int c = 0; c < 300; c++)
            cycle(N'($urandom), N'($urandom) & N'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
